// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared types and constants for the hand controller link
package controller_pkg;

  localparam logic [7:0] CTRL_SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CTRL_JOY_CENTRE = 8'h80;

  typedef struct packed {
    logic [7:0] buttons;
    logic [7:0] joystick_x;
    logic [7:0] joystick_y;
  } controller_state_t;

  typedef enum logic [1:0] {
    HUNT,
    BTN,
    JX,
    JY
  } rx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchroniser with a registered rising-edge pulse
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_raw,
  output logic rise_out
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The pulse is registered, so it trails the synchronised level by one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      rise_out <= 1'b0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], sig_raw};
      prev_q   <= sync_q[STAGES-1];
      rise_out <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/controller_spi_rx.sv
// rtl/controller_spi_rx.sv - controller serial receiver, packet framer and snapshot publisher
module controller_spi_rx
  import controller_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = CTRL_SYNC_BYTE,
  parameter int         IDLE_TIMEOUT = 2000,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       chip_clk_raw,
  input  logic       chip_data_raw,
  output logic [7:0] buttons_out,
  output logic [7:0] joystick_x_out,
  output logic [7:0] joystick_y_out,
  output logic       valid_out,
  output logic [7:0] last_raw_byte_out,
  output logic [7:0] err_count_out
);

  localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(IDLE_TIMEOUT - 1);

  logic                 chip_rise;
  logic [SYNC_STAGES:0] data_q;
  logic                 data_bit;
  logic [7:0]           shift_reg;
  logic [2:0]           bit_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [7:0]           btn_hold;
  logic [7:0]           jx_hold;
  logic [7:0]           err_count;
  controller_state_t    snap_q;
  rx_state_t            state;
  rx_state_t            state_next;

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       timeout_hit;
  logic       abort;
  logic       hold_btn;
  logic       hold_jx;
  logic       commit;
  logic       sync_err;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_clk_sync (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .sig_raw (chip_clk_raw),
    .rise_out(chip_rise)
  );

  // One extra flop on data matches the registered edge pulse on the clock line.
  assign data_bit    = data_q[SYNC_STAGES];
  assign rx_byte     = {shift_reg[6:0], data_bit};
  assign byte_done   = chip_rise && (bit_cnt == 3'd7);
  assign timeout_hit = !chip_rise && (idle_cnt == IDLE_PRE);
  assign abort       = timeout_hit && ((bit_cnt != 3'd0) || (state != HUNT));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_btn   = 1'b0;
    hold_jx    = 1'b0;
    commit     = 1'b0;
    sync_err   = 1'b0;
    if (timeout_hit) begin
      state_next = HUNT;
    end else if (byte_done) begin
      case (state)
        HUNT: begin
          if (rx_byte == SYNC_BYTE) begin
            state_next = BTN;
          end else begin
            sync_err = 1'b1;
          end
        end
        BTN: begin
          hold_btn   = 1'b1;
          state_next = JX;
        end
        JX: begin
          hold_jx    = 1'b1;
          state_next = JY;
        end
        JY: begin
          commit     = 1'b1;
          state_next = HUNT;
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q            <= '0;
      shift_reg         <= 8'h00;
      bit_cnt           <= 3'd0;
      idle_cnt          <= '0;
      btn_hold          <= 8'h00;
      jx_hold           <= 8'h00;
      err_count         <= 8'h00;
      snap_q            <= '{buttons: 8'h00, joystick_x: CTRL_JOY_CENTRE, joystick_y: CTRL_JOY_CENTRE};
      valid_out         <= 1'b0;
      last_raw_byte_out <= 8'h00;
    end else begin
      data_q    <= {data_q[SYNC_STAGES-1:0], chip_data_raw};
      valid_out <= commit;

      if (chip_rise) begin
        shift_reg <= rx_byte;
        bit_cnt   <= bit_cnt + 3'd1;
        idle_cnt  <= '0;
        if (bit_cnt == 3'd7) begin
          last_raw_byte_out <= rx_byte;
        end
      end else begin
        if (idle_cnt != IDLE_MAX) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        if (timeout_hit) begin
          bit_cnt <= 3'd0;
        end
      end

      if (hold_btn) begin
        btn_hold <= rx_byte;
      end
      if (hold_jx) begin
        jx_hold <= rx_byte;
      end
      // All three fields land on one edge so the CPU never sees a torn snapshot.
      if (commit) begin
        snap_q <= '{buttons: btn_hold, joystick_x: jx_hold, joystick_y: rx_byte};
      end
      if (sync_err || abort) begin
        err_count <= sat_inc8(err_count);
      end
    end
  end

  assign buttons_out    = snap_q.buttons;
  assign joystick_x_out = snap_q.joystick_x;
  assign joystick_y_out = snap_q.joystick_y;
  assign err_count_out  = err_count;

endmodule

// File: tb/tb_controller_spi_rx.sv
// tb/tb_controller_spi_rx.sv - scoreboard bench for the controller serial receiver
module tb_controller_spi_rx;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       chip_clk_raw = 1'b0;
  logic       chip_data_raw = 1'b0;
  logic [7:0] buttons_out;
  logic [7:0] joystick_x_out;
  logic [7:0] joystick_y_out;
  logic       valid_out;
  logic [7:0] last_raw_byte_out;
  logic [7:0] err_count_out;

  int          tests = 0;
  int          fails = 0;
  int          valid_seen = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_snap;

  controller_spi_rx dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .chip_clk_raw     (chip_clk_raw),
    .chip_data_raw    (chip_data_raw),
    .buttons_out      (buttons_out),
    .joystick_x_out   (joystick_x_out),
    .joystick_y_out   (joystick_y_out),
    .valid_out        (valid_out),
    .last_raw_byte_out(last_raw_byte_out),
    .err_count_out    (err_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: every valid cycle must match the oldest expected snapshot.
  always @(negedge clk_in) begin
    if (!rst_in && valid_out) begin
      valid_seen = valid_seen + 1;
      tests = tests + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_valid got %h_%h_%h with no packet expected",
                 buttons_out, joystick_x_out, joystick_y_out);
      end else begin
        exp_snap = exp_q.pop_front();
        if ({buttons_out, joystick_x_out, joystick_y_out} !== exp_snap) begin
          fails = fails + 1;
          $display("FAIL snapshot got %h_%h_%h expected %h_%h_%h",
                   buttons_out, joystick_x_out, joystick_y_out,
                   exp_snap[23:16], exp_snap[15:8], exp_snap[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in        = 1'b1;
    chip_clk_raw  = 1'b0;
    chip_data_raw = 1'b0;
    idle(3);
    rst_in = 1'b0;
    idle(2);
    valid_seen = 0;
  endtask

  task automatic send_bit(input logic b, input int ph);
    chip_data_raw = b;
    chip_clk_raw  = 1'b0;
    idle(ph);
    chip_clk_raw = 1'b1;
    idle(ph);
    chip_clk_raw = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int ph);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], ph);
    end
  endtask

  task automatic send_packet(input logic [7:0] btn, input logic [7:0] jx, input logic [7:0] jy);
    exp_q.push_back({btn, jx, jy});
    send_byte(8'hA5, 10);
    send_byte(btn, 10);
    send_byte(jx, 10);
    send_byte(jy, 10);
    idle(8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_buttons"}, 32'(buttons_out), 32'h00);
    check({tag, "_x"}, 32'(joystick_x_out), 32'h80);
    check({tag, "_y"}, 32'(joystick_y_out), 32'h80);
  endtask

  initial begin
    logic [7:0] partial;

    // Reset state
    do_reset();
    check_reset_outputs("rst");
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_last_raw", 32'(last_raw_byte_out), 32'h00);
    check("rst_err", 32'(err_count_out), 32'h00);

    // Clean packet
    send_packet(8'h03, 8'h40, 8'hC0);
    check("t1_valid_cycles", 32'(valid_seen), 32'd1);
    check("t1_err", 32'(err_count_out), 32'h00);
    check("t1_last_raw", 32'(last_raw_byte_out), 32'hC0);

    // Bad sync byte followed by a good packet
    do_reset();
    send_byte(8'h5A, 10);
    idle(8);
    check("t2_err_after_bad", 32'(err_count_out), 32'h01);
    check("t2_last_raw_bad", 32'(last_raw_byte_out), 32'h5A);
    send_packet(8'h11, 8'h22, 8'h33);
    check("t2_valid_cycles", 32'(valid_seen), 32'd1);
    check("t2_err", 32'(err_count_out), 32'h01);
    check("t2_last_raw", 32'(last_raw_byte_out), 32'h33);

    // Timeout mid-packet, held bytes never leak out
    do_reset();
    send_byte(8'hA5, 10);
    send_byte(8'h11, 10);
    idle(2100);
    check("t3_err_timeout", 32'(err_count_out), 32'h01);
    check_reset_outputs("t3_hold");
    check("t3_no_valid", 32'(valid_seen), 32'd0);
    send_packet(8'h44, 8'h55, 8'h66);
    check("t3_valid_cycles", 32'(valid_seen), 32'd1);
    idle(2100);
    check("t3_err_silent_idle", 32'(err_count_out), 32'h01);

    // Partial byte then timeout realigns bit counting
    do_reset();
    partial = 8'hFF;
    for (int i = 7; i >= 3; i--) begin
      send_bit(partial[i], 10);
    end
    idle(2100);
    check("t4_err_timeout", 32'(err_count_out), 32'h01);
    send_packet(8'h77, 8'h88, 8'h99);
    check("t4_valid_cycles", 32'(valid_seen), 32'd1);
    check("t4_last_raw", 32'(last_raw_byte_out), 32'h99);

    // Asynchronous reset during the JX byte
    do_reset();
    send_packet(8'h01, 8'h02, 8'h03);
    send_byte(8'hA5, 10);
    send_byte(8'h12, 10);
    partial = 8'h34;
    for (int i = 7; i >= 4; i--) begin
      send_bit(partial[i], 10);
    end
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    check("t5_async_last_raw", 32'(last_raw_byte_out), 32'h00);
    check("t5_async_valid", 32'(valid_out), 32'h0);
    check("t5_valid_before_rst", 32'(valid_seen), 32'd1);
    idle(2);
    rst_in = 1'b0;
    valid_seen = 0;
    idle(2);
    send_packet(8'h21, 8'h43, 8'h65);
    check("t5_valid_after_rst", 32'(valid_seen), 32'd1);
    check("t5_err", 32'(err_count_out), 32'h00);

    // Error counter saturation
    do_reset();
    for (int n = 0; n < 254; n++) begin
      send_byte(8'h00, 4);
    end
    idle(8);
    check("t6_err_254", 32'(err_count_out), 32'hFE);
    for (int n = 254; n < 300; n++) begin
      send_byte(8'h00, 4);
    end
    idle(8);
    check("t6_err_sat", 32'(err_count_out), 32'hFF);
    check("t6_no_valid", 32'(valid_seen), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
